// File: rtl/display_scan_mux_n.sv
// Time-multiplexed N-digit scanner with leading-zero blanking, decimal points, PWM brightness and double-buffered updates.
// Latency: an/bcd_out/dp_out/blank_out are registered, one cycle after (scan index, prescaler); frame_done/update_pending come straight from state registers.
// Backpressure: none; load is a strobe that is always accepted, and a newer load overwrites older shadow data.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   load                : capture digits_in/dp_in (shadow, or straight to active on a frame boundary)
//   digits_in, dp_in    : BCD nibble and decimal point per digit (digit 0 = rightmost)
//   digit_en            : per-digit anode enable (the slot is still consumed when disabled)
//   lz_suppress         : blank leading zeros
//   brightness          : duty level, all-ones = full duty
//   an                  : active-low anodes, at most one low
//   bcd_out, dp_out     : nibble and decimal point for the current digit
//   blank_out           : tells the decoder to turn all segments off
//   frame_done          : one-cycle pulse on the frame boundary cycle
//   update_pending      : shadow holds data not yet applied
module display_scan_mux_n #(
  parameter int NUM_DIGITS  = 8,
  parameter int PRESCALE    = 25000,
  parameter int BRIGHT_BITS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lz_suppress,
  input  logic [BRIGHT_BITS-1:0]    brightness,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [3:0]                bcd_out,
  output logic                      dp_out,
  output logic                      blank_out,
  output logic                      frame_done,
  output logic                      update_pending
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  // Wide enough for (2^BRIGHT_BITS)*PRESCALE without overflow.
  localparam int OW = PW + BRIGHT_BITS + 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [OW-1:0] PRESC_W   = OW'(PRESCALE);

  logic [PW-1:0]                  r_presc;
  logic [IW-1:0]                  r_idx;
  logic [BRIGHT_BITS-1:0]         r_bright;
  logic [NUM_DIGITS-1:0][3:0]     r_sh_dig;
  logic [NUM_DIGITS-1:0]          r_sh_dp;
  logic [NUM_DIGITS-1:0][3:0]     r_act_dig;
  logic [NUM_DIGITS-1:0]          r_act_dp;
  logic                           r_pending;

  logic                           w_wrap;
  logic                           w_boundary;
  logic [OW-1:0]                  w_on_time;
  logic                           w_elig;
  logic [NUM_DIGITS-1:0]          w_supp;
  logic                           w_on;
  logic [NUM_DIGITS-1:0]          w_an_nxt;

  assign w_wrap     = (r_presc == PRESC_MAX);
  assign w_boundary = w_wrap && (r_idx == '0);

  // On-time in prescaler ticks; all-ones brightness yields exactly PRESCALE (full duty).
  assign w_on_time = (((OW'(r_bright) + OW'(1)) * PRESC_W) >> BRIGHT_BITS);
  // Prescaler 0 is always eligible because PRESCALE >= 2^BRIGHT_BITS, so the
  // slot register sampled on that same cycle is never needed before it is valid.
  assign w_elig    = (OW'(r_presc) < w_on_time);

  // A digit is a leading zero when it and every digit to its left hold 0 with no
  // decimal point. Disabled digits still count; digit 0 is always shown.
  always_comb begin
    logic v_run;
    v_run  = 1'b1;
    w_supp = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_run     = v_run && (r_act_dig[i] == 4'd0) && !r_act_dp[i];
      w_supp[i] = lz_suppress && (i != 0) && v_run;
    end
  end

  assign w_on = digit_en[r_idx] && w_elig && !w_supp[r_idx];

  always_comb begin
    w_an_nxt = '1;
    if (w_on) begin
      w_an_nxt[r_idx] = 1'b0;
    end
  end

  // Scan counters: the index walks from the leftmost digit down to digit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc  <= '0;
      r_idx    <= IDX_MAX;
      r_bright <= '0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + PW'(1);
      if (w_wrap) begin
        r_idx <= (r_idx == '0) ? IDX_MAX : r_idx - IW'(1);
      end
      if (r_presc == '0) begin
        r_bright <= brightness;
      end
    end
  end

  // Double buffer: active data changes only on the frame boundary, so a frame is
  // never drawn with a mix of old and new digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_dig  <= '0;
      r_sh_dp   <= '0;
      r_act_dig <= '0;
      r_act_dp  <= '0;
      r_pending <= 1'b0;
    end else if (w_boundary) begin
      r_pending <= 1'b0;
      if (load) begin
        // Fresh data on the boundary goes straight to the display.
        r_act_dig <= digits_in;
        r_act_dp  <= dp_in;
      end else if (r_pending) begin
        r_act_dig <= r_sh_dig;
        r_act_dp  <= r_sh_dp;
      end
    end else if (load) begin
      r_sh_dig  <= digits_in;
      r_sh_dp   <= dp_in;
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an        <= '1;
      bcd_out   <= 4'd0;
      dp_out    <= 1'b0;
      blank_out <= 1'b1;
    end else begin
      an        <= w_an_nxt;
      bcd_out   <= r_act_dig[r_idx];
      dp_out    <= r_act_dp[r_idx] && w_on;
      blank_out <= !w_on;
    end
  end

  assign frame_done     = w_boundary;
  assign update_pending = r_pending;

endmodule

// File: doc/display_scan_mux_n.md
Name: display_scan_mux_n

Overview:
Parametrised successor to the team's 4-digit time-multiplexed 7-segment scanner. It scans NUM_DIGITS digits with a programmable refresh prescaler and per-digit enables. It adds leading-zero suppression, per-digit decimal points, PWM brightness control, and tear-free double-buffered digit updates. It sits between the BCD/counter logic and the segment decoder, driving active-low anodes plus a BCD nibble and blank flag to the decoder.

Parameters:
NUM_DIGITS, 8, number of digits scanned; legal 2..16
PRESCALE, 25000, clk cycles per digit slot; legal ≥ 2^BRIGHT_BITS (1 kHz/digit at 25 MHz)
BRIGHT_BITS, 3, width of the brightness control

Ports:
clk  in  1  system clock (25 MHz nominal)
reset  in  1  synchronous, active-high reset
load  in  1  single-cycle strobe; capture digits_in/dp_in into shadow registers
digits_in  in  4*NUM_DIGITS  BCD digits; nibble i = digit i, digit 0 = rightmost
dp_in  in  NUM_DIGITS  decimal-point request per digit
digit_en  in  NUM_DIGITS  per-digit enable; 0 = slot consumed but anode held off
lz_suppress  in  1  1 = blank leading zeros
brightness  in  BRIGHT_BITS  duty level; 0 = minimum, all-ones = full duty
an  out  NUM_DIGITS  anodes, active low, at most one low per cycle
bcd_out  out  4  BCD nibble of the current digit
dp_out  out  1  decimal point for the current digit, active high
blank_out  out  1  1 = decoder drives all segments off
frame_done  out  1  1-cycle pulse at each frame boundary
update_pending  out  1  shadow holds data not yet applied

Behaviour:
- Reset values, applied on the clk edge with reset=1:
  - Counters: prescaler 0, scan index NUM_DIGITS-1.
  - Shadow/active digits and DPs 0; pending 0.
  - Outputs: an all ones, bcd_out 0, dp_out 0, blank_out 1, frame_done 0, update_pending 0.
  - Reset mid-scan aborts the frame; shadow data is discarded.
- Prescaler: counts 0..PRESCALE-1 and wraps.
  - On wrap, scan index decrements (leftmost digit first); after 0 it wraps to NUM_DIGITS-1.
  - Frame period = NUM_DIGITS*PRESCALE cycles regardless of digit_en.
- Frame boundary: the cycle where prescaler wraps with index = 0.
  - frame_done=1 for that cycle.
  - If pending: active <= shadow, pending <= 0.
- Load:
  - load=1 in a non-boundary cycle: shadow <= inputs, pending <= 1; a repeated load overwrites the shadow.
  - load=1 on the boundary cycle: active <= digits_in/dp_in directly (bypass), pending stays 0.
  - Active registers never change mid-frame.
- Brightness:
  - Sampled into a slot register when prescaler = 0.
  - ON_TIME = ((b+1)*PRESCALE) >> BRIGHT_BITS, computed at width ≥ clog2(PRESCALE)+BRIGHT_BITS+1.
  - Anode eligible while prescaler < ON_TIME; all-ones gives full duty.
- Leading-zero suppression (on active registers):
  - Digit i is suppressed iff lz_suppress=1, i≠0, and for all j≥i, digit j = 0 and dp j = 0.
  - Digit 0 is never suppressed; disabled digits still take part in the zero test.
- Outputs, registered, 1-cycle latency from (index, prescaler):
  - an[idx]=0 iff digit_en[idx] & eligible & !suppressed; all other bits 1.
  - bcd_out = active digit idx.
  - dp_out = dp[idx] & an-active.
  - blank_out = !(an-active).
  - Non-BCD nibbles (A–F) are passed through unchanged.
- digit_en, lz_suppress: sampled live each cycle, no buffering.

Test Plan:
- NUM_DIGITS=4, PRESCALE=4, BRIGHT_BITS=2, brightness=3, all enabled, load 4321 -> after first boundary, per 4-cycle slot: an=0111/1011/1101/1110 with bcd_out 4/3/2/1; frame_done every 16 cycles.
- Same config, brightness=0 -> ON_TIME=1: an low 1 of 4 cycles per slot, blank_out=1 in the other 3.
- lz_suppress=1, load 0050, dp_in=0 -> digits 3,2 blank (an bit high, blank_out=1), digits 1,0 show 5,0; load 0000 -> only digit 0 lit, showing 0; dp_in=0100 with 0000 -> digits 2..0 lit.
- Load 1111 mid-frame, then load 2222 before the boundary -> display stays old until boundary, then 2222; update_pending 1→0 at frame_done; load on the boundary cycle with 3333 -> 3333 applied immediately, pending stays 0.
- digit_en=1010 -> an bits 0,2 always high; frame period unchanged at 16 cycles.
- Assert reset mid-slot with pending=1 -> next cycle an=1111, blank_out=1, pending=0, scan restarts at digit 3 with all-zero display data.
